uart_tx_fifo: RTL

- Downstream consumer of the UART write-detect pulse.
- Each one-cycle `en` pulse (CPU store to the UART data address 0xB000_0000) pushes `wdata[7:0]` into a small FIFO.
- A baud-rate state machine drains the FIFO and serialises each byte as 8N1 on `txd`.
- Status outputs let the CPU poll for backpressure.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_tx_fifo_if.sv | 31 +++
 rtl/uart_tx_fifo_sync_fifo.sv | 81 ++++++++
 rtl/uart_tx_fifo.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

  localparam int UART_DATA_BITS            = 8;
  localparam int UART_DEFAULT_CLKS_PER_BIT = 434;

  // Transmitter frame phases.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// CPU-facing push strobe plus serial output and status lines of the UART transmitter.
interface uart_tx_fifo_if
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
);

  localparam int COUNT_W = $clog2(FIFO_DEPTH) + 1;

  logic                      en;
  logic [UART_DATA_BITS-1:0] wdata;
  logic                      txd;
  logic                      busy;
  logic                      full;
  logic                      empty;
  logic                      overflow;
  logic [COUNT_W-1:0]        count;

  // Write-detect side: pushes bytes and polls status.
  modport master (
    output en, wdata,
    input  txd, busy, full, empty, overflow, count
  );

  // Transmitter side.
  modport slave (
    input  en, wdata,
    output txd, busy, full, empty, overflow, count
  );

endinterface

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Small synchronous FIFO; the head entry is readable on dout without a pop.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Full/empty come from the registered count, so a push while full is
  // dropped even when a pop frees a slot in the same cycle.
  assign full      = (count_q == CNT_DEPTH);
  assign empty     = (count_q == {CNT_W{1'b0}});
  assign count     = count_q;
  assign dout      = mem_q[rd_ptr_q];
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;

  // Next pointers and occupancy; power-of-two depth lets pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset discards all queued entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter fed by single-cycle CPU store strobes.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_fifo_if.slave  bus
);

  localparam int COUNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int BAUD_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
  localparam logic [2:0]        LAST_BIT  = 3'(UART_DATA_BITS - 1);

  tx_state_t                 state_q, state_d;
  logic [BAUD_W-1:0]         baud_q, baud_d;
  logic [2:0]                bit_q, bit_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      txd_q, txd_d;
  logic                      overflow_q, overflow_d;
  logic                      pop_s;
  logic [UART_DATA_BITS-1:0] fifo_dout_s;
  logic                      fifo_full_s;
  logic                      fifo_empty_s;
  logic [COUNT_W-1:0]        fifo_count_s;

  sync_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.en),
    .din   (bus.wdata),
    .pop   (pop_s),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  assign bus.txd      = txd_q;
  assign bus.busy     = (state_q != IDLE) | ~fifo_empty_s;
  assign bus.full     = fifo_full_s;
  assign bus.empty    = fifo_empty_s;
  assign bus.overflow = overflow_q;
  assign bus.count    = fifo_count_s;

  // FSM state, baud counter, bit index, shifter and registered serial line.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= {BAUD_W{1'b0}};
      bit_q   <= 3'd0;
      shift_q <= {UART_DATA_BITS{1'b0}};
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
    end
  end

  // Frame sequencing: pop in IDLE, then advance on the last tick of each bit period.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop_s   = 1'b0;
    case (state_q)
      IDLE: begin
        baud_d = {BAUD_W{1'b0}};
        bit_d  = 3'd0;
        if (!fifo_empty_s) begin
          pop_s   = 1'b1;
          shift_d = fifo_dout_s;
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = {BAUD_W{1'b0}};
          bit_d   = 3'd0;
          state_d = DATA;
        end else begin
          baud_d  = baud_q + BAUD_ONE;
        end
      end
      DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = {BAUD_W{1'b0}};
          shift_d = {1'b0, shift_q[UART_DATA_BITS-1:1]};
          if (bit_q == LAST_BIT) begin
            state_d = STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
          end
        end else begin
          baud_d  = baud_q + BAUD_ONE;
        end
      end
      STOP: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = {BAUD_W{1'b0}};
          state_d = IDLE;
        end else begin
          baud_d  = baud_q + BAUD_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        baud_d  = {BAUD_W{1'b0}};
        bit_d   = 3'd0;
      end
    endcase
  end

  // Serial level for the coming cycle, derived from next state so txd is a flop.
  always_comb begin
    txd_d = 1'b1;
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  // Sticky overflow: set when a push arrives while the FIFO reports full.
  always_comb begin
    if (bus.en && fifo_full_s) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Overflow flag register; cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

endmodule
